// File: rtl/timer_display_pkg.sv
// Shared 7-seg constants and BCD helper for the timer display.
// Segment codes are {g,f,e,d,c,b,a}, active-low.
package timer_display_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [5:0] MAX_VAL = 6'd59;

  // {tens, ones} of a field clamped to MAX_VAL
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] c;
    c = (v > MAX_VAL) ? MAX_VAL : v;
    return {4'(c / 6'd10), 4'(c % 6'd10)};
  endfunction

endpackage

// File: rtl/timer_display_seg7_decode.sv
// BCD digit to active-low 7-segment pattern.
// Codes 10..15 render blank.
module seg7_decode
  import timer_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/timer_display.sv
// 4-digit multiplexed display of the countdown timer value.
// Captures the slow-domain time, scans digits, blinks on expiry.
module timer_display
  import timer_display_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int BLINK_HZ   = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] sec_i,
  input  logic [5:0] min_i,
  input  logic [5:0] hour_i,
  output logic [3:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o,
  output logic       expired_o
);

  localparam int DIV  = CLK_HZ / REFRESH_HZ;
  localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(HALF - 1);

  logic [17:0]   in_w;
  logic [17:0]   s1;
  logic [17:0]   cap;
  logic          s1_ok;
  logic          valid;
  logic          shown_ok;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [3:0]    cur;
  logic [BW-1:0] bcnt;
  logic          phase;
  logic          exp_d;
  logic          lit;
  logic [7:0]    hb, mb, sb;
  logic [15:0]   digits;
  logic [3:0]    sel;
  logic [6:0]    seg_d;

  assign in_w = {hour_i, min_i, sec_i};

  // a value is taken only after it is seen on two consecutive edges
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1    <= '0;
      s1_ok <= 1'b0;
      cap   <= '0;
      valid <= 1'b0;
    end else begin
      s1    <= in_w;
      s1_ok <= 1'b1;
      if (s1_ok && in_w == s1) begin
        cap   <= s1;
        valid <= 1'b1;
      end
    end
  end

  always_comb begin
    hb     = to_bcd(cap[17:12]);
    mb     = to_bcd(cap[11:6]);
    sb     = to_bcd(cap[5:0]);
    digits = (cap[17:12] != 6'd0) ? {hb, mb} : {mb, sb};
    sel    = digits[3:0];
    unique case (idx)
      2'd0: sel = digits[3:0];
      2'd1: sel = digits[7:4];
      2'd2: sel = digits[11:8];
      2'd3: sel = digits[15:12];
    endcase
  end

  assign exp_d = valid && (cap == 18'd0);

  // digit latched at slot start; also tracked until first display
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt      <= '0;
      idx      <= 2'd0;
      cur      <= 4'd0;
      shown_ok <= 1'b0;
    end else begin
      shown_ok <= valid;
      if (cnt == '0 || !shown_ok)
        cur <= sel;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      expired_o <= 1'b0;
      bcnt      <= '0;
      phase     <= 1'b0;
    end else begin
      expired_o <= exp_d;
      if (exp_d && !expired_o) begin
        bcnt  <= '0;
        phase <= 1'b1;
      end else if (expired_o) begin
        if (bcnt == BLK_LAST) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + BW'(1);
        end
      end
    end
  end

  seg7_decode u_dec (
    .bcd_i (cur),
    .seg_o (seg_d)
  );

  assign lit = shown_ok && (cnt != '0) && !(expired_o && !phase);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      an_o  <= AN_OFF;
      seg_o <= SEG_BLANK;
      dp_o  <= 1'b1;
    end else begin
      an_o  <= lit ? ~(4'b0001 << idx) : AN_OFF;
      seg_o <= lit ? seg_d : SEG_BLANK;
      dp_o  <= !(lit && idx == 2'd2);
    end
  end

endmodule

// File: tb/tb_timer_display.sv
// Scoreboard bench for timer_display (DIV=4, HALF=10).
// Expected digit slots are queued on drive and popped on scan.
module tb_timer_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] sec, mn, hr;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, expd;

  int n_cmp = 0;
  int n_bad = 0;

  logic [11:0] sb_q[$];
  logic [6:0]  seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always #5 clk = ~clk;

  timer_display #(
    .CLK_HZ     (1000),
    .REFRESH_HZ (250),
    .BLINK_HZ   (50)
  ) dut (
    .clk_i     (clk),
    .reset_i   (rst),
    .sec_i     (sec),
    .min_i     (mn),
    .hour_i    (hr),
    .an_o      (an),
    .seg_o     (seg),
    .dp_o      (dp),
    .expired_o (expd)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > 59) ? 59 : v;
  endfunction

  task automatic drive(input int h, input int m, input int s);
    hr  = 6'(h);
    mn  = 6'(m);
    sec = 6'(s);
  endtask

  task automatic push_exp(input int h, input int m, input int s);
    int a, b;
    int d [4];
    logic [3:0] e_an;
    logic       e_dp;
    if (h != 0) begin
      a = clamp(h);
      b = clamp(m);
    end else begin
      a = clamp(m);
      b = clamp(s);
    end
    d[0] = b % 10;
    d[1] = b / 10;
    d[2] = a % 10;
    d[3] = a / 10;
    for (int i = 0; i < 4; i++) begin
      e_an = ~(4'b0001 << i);
      e_dp = (i != 2);
      sb_q.push_back({e_an, seg_tab[d[i]], e_dp});
    end
  endtask

  task automatic scan_check();
    logic [3:0]  prev;
    logic [11:0] e;
    bit          found;
    found = 1'b0;
    prev  = an;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (prev == 4'hF && an == 4'b1110) begin
        found = 1'b1;
        break;
      end
      prev = an;
    end
    check("sync", 32'(found), 32'd1);
    if (!found) begin
      sb_q.delete();
      return;
    end
    for (int s = 0; s < 4; s++) begin
      if (sb_q.size() == 0) begin
        check("queue_empty", 32'd0, 32'd1);
        return;
      end
      e = sb_q.pop_front();
      for (int c = 0; c < 3; c++) begin
        if (!(s == 0 && c == 0)) @(negedge clk);
        check($sformatf("slot%0d", s), {20'd0, an, seg, dp}, {20'd0, e});
      end
      if (s < 3) begin
        @(negedge clk);
        check("gap", {20'd0, an, seg, dp}, {20'd0, 4'hF, 7'h7F, 1'b1});
      end
    end
  endtask

  task automatic show(input int h, input int m, input int s);
    drive(h, m, s);
    push_exp(h, m, s);
    repeat (4) @(negedge clk);
    scan_check();
  endtask

  initial begin
    int cnt, run, maxrun, longruns, litcnt, badseg, lows;
    bit got;

    rst = 1'b1;
    drive(0, 5, 0);
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_exp", 32'(expd), 32'd0);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rel_blank", 32'(an), 32'hF);
    end

    show(0, 5, 0);
    show(1, 23, 45);
    show(0, 5, 0);

    sec = 6'd7;
    @(negedge clk);
    sec = 6'd0;
    push_exp(0, 5, 0);
    repeat (4) @(negedge clk);
    scan_check();

    mn = 6'd0;
    @(negedge clk);
    mn = 6'd5;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (expd) cnt++;
    end
    check("glitch_exp", 32'(cnt), 32'd0);

    mn = 6'd0;
    repeat (2) @(negedge clk);
    mn = 6'd5;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (expd) cnt++;
    end
    check("hold_exp", 32'(cnt != 0), 32'd1);

    show(0, 1, 63);
    show(0, 63, 10);

    drive(0, 0, 0);
    got = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (expd) begin
        got = 1'b1;
        break;
      end
    end
    check("exp_rise", 32'(got), 32'd1);

    run = 0; maxrun = 0; longruns = 0;
    litcnt = 0; badseg = 0; lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (!expd) lows++;
      if (an == 4'hF) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else begin
        if (run >= 10) longruns++;
        run = 0;
        litcnt++;
        if (seg != 7'h40) badseg++;
      end
    end
    if (run >= 10) longruns++;
    check("exp_held", 32'(lows), 32'd0);
    check($sformatf("blink_off_len_%0d", maxrun),
          32'(maxrun >= 10 && maxrun <= 12), 32'd1);
    check("blink_off_phases", 32'(longruns >= 2), 32'd1);
    check("blink_on_lit", 32'(litcnt > 0), 32'd1);
    check("blink_digit0", 32'(badseg), 32'd0);

    drive(0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (!expd) break;
    end
    check("exp_fall", 32'(expd), 32'd0);
    push_exp(0, 1, 0);
    repeat (2) @(negedge clk);
    scan_check();

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (an != 4'hF) break;
    end
    rst = 1'b1;
    #1;
    check("mid_rst_an", 32'(an), 32'hF);
    check("mid_rst_seg", 32'(seg), 32'h7F);
    check("mid_rst_dp", 32'(dp), 32'd1);
    check("mid_rst_exp", 32'(expd), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (an != 4'hF) break;
    end
    check("post_rst_an", 32'(an), 32'hE);
    check("post_rst_seg", 32'(seg), 32'h40);

    show(1, 23, 45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
